// File: rtl/seg_msg_scanner.sv
// Time-multiplexed 7-segment message scanner: a writable character buffer plus
// refresh, scroll and blink timing. AN/led are registered one cycle behind the scan state.
module seg_msg_scanner #(
  parameter int NUM_DIGITS  = 8,
  parameter int MSG_DEPTH   = 16,
  parameter int REFRESH_DIV = 100000,
  parameter int SCROLL_DIV  = 25000000,
  parameter int BLINK_DIV   = 50000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
  input  logic [6:0]                   wr_char,
  input  logic [$clog2(MSG_DEPTH):0]   msg_len,
  input  logic [1:0]                   mode,
  input  logic                         start,
  output logic [NUM_DIGITS-1:0]        AN,
  output logic [6:0]                   led,
  output logic                         scroll_wrap
);

  localparam int AW = $clog2(MSG_DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = $clog2(MSG_DEPTH + NUM_DIGITS) + 1;
  localparam int PW = $clog2(NUM_DIGITS);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int CW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [6:0] LED_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_SCROLL = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_BLANK  = 2'b11
  } mode_e;

  logic [6:0]            r_buf [MSG_DEPTH];
  logic [RW-1:0]         r_ref_cnt;
  logic [PW-1:0]         r_pos;
  logic [SW-1:0]         r_offset;
  logic [CW-1:0]         r_scr_cnt;
  logic [BW-1:0]         r_blk_cnt;
  logic                  r_phase;
  logic [1:0]            r_prev_mode;
  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_led;
  logic                  r_scroll_wrap;

  mode_e                 w_mode;
  logic [LW-1:0]         w_len;
  logic [SW-1:0]         w_ring;
  logic                  w_restart;
  logic                  w_ref_tc;
  logic                  w_scr_tc;
  logic                  w_blk_tc;
  logic [SW-1:0]         w_sum;
  logic [SW-1:0]         w_scr_idx;
  logic [SW-1:0]         w_idx;
  logic [6:0]            w_char;
  logic [NUM_DIGITS-1:0] w_an_scan;
  logic [NUM_DIGITS-1:0] w_an_next;
  logic [6:0]            w_led_next;
  logic [SW-1:0]         w_offset_next;
  logic                  w_wrap_next;

  assign w_mode    = mode_e'(mode);
  assign w_len     = (msg_len > LW'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : msg_len;
  // Scroll ring: the message followed by one screen of blanks.
  assign w_ring    = SW'(w_len) + SW'(NUM_DIGITS);
  assign w_restart = start | (mode != r_prev_mode);
  assign w_ref_tc  = (r_ref_cnt == RW'(REFRESH_DIV - 1));
  assign w_scr_tc  = (r_scr_cnt == CW'(SCROLL_DIV - 1));
  assign w_blk_tc  = (r_blk_cnt == BW'(BLINK_DIV - 1));

  always_comb begin
    w_sum      = r_offset + SW'(r_pos);
    w_scr_idx  = (w_sum >= w_ring) ? (w_sum - w_ring) : w_sum;
    w_idx      = (w_mode == MODE_SCROLL) ? w_scr_idx : SW'(r_pos);
    w_char     = 7'h00;
    if (w_idx < SW'(w_len)) w_char = r_buf[w_idx[AW-1:0]];
    w_an_scan  = '1;
    w_an_scan[PW'(NUM_DIGITS - 1) - r_pos] = 1'b0;
    w_an_next  = w_an_scan;
    w_led_next = ~w_char;
    case (w_mode)
      MODE_BLANK: begin
        w_an_next  = '1;
        w_led_next = LED_BLANK;
      end
      MODE_BLINK: if (!r_phase) w_an_next = '1;
      default: ;
    endcase
  end

  // Restart outranks a shrink, which outranks a scroll step; only a step wrap pulses.
  always_comb begin
    w_offset_next = r_offset;
    w_wrap_next   = 1'b0;
    if (w_restart) begin
      w_offset_next = '0;
    end else if (r_offset >= w_ring) begin
      w_offset_next = '0;
    end else if (w_scr_tc) begin
      if (r_offset == w_ring - SW'(1)) begin
        w_offset_next = '0;
        w_wrap_next   = 1'b1;
      end else begin
        w_offset_next = r_offset + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MSG_DEPTH; i++) r_buf[i] <= '0;
      r_ref_cnt     <= '0;
      r_pos         <= '0;
      r_offset      <= '0;
      r_scr_cnt     <= '0;
      r_blk_cnt     <= '0;
      r_phase       <= 1'b1;
      r_prev_mode   <= 2'b00;
      r_an          <= '1;
      r_led         <= LED_BLANK;
      r_scroll_wrap <= 1'b0;
    end else begin
      if (wr_en) r_buf[wr_addr] <= wr_char;
      if (w_ref_tc) begin
        r_ref_cnt <= '0;
        r_pos     <= (r_pos == PW'(NUM_DIGITS - 1)) ? '0 : r_pos + PW'(1);
      end else begin
        r_ref_cnt <= r_ref_cnt + RW'(1);
      end
      if (w_restart || w_scr_tc) r_scr_cnt <= '0;
      else                       r_scr_cnt <= r_scr_cnt + CW'(1);
      if (w_restart) begin
        r_blk_cnt <= '0;
        r_phase   <= 1'b1;
      end else if (w_blk_tc) begin
        r_blk_cnt <= '0;
        r_phase   <= ~r_phase;
      end else begin
        r_blk_cnt <= r_blk_cnt + BW'(1);
      end
      r_offset      <= w_offset_next;
      r_prev_mode   <= mode;
      r_an          <= w_an_next;
      r_led         <= w_led_next;
      r_scroll_wrap <= w_wrap_next;
    end
  end

  assign AN          = r_an;
  assign led         = r_led;
  assign scroll_wrap = r_scroll_wrap;

endmodule
